// File: rtl/ni_inject_arbiter_if.sv
// Handshake bundle between the injection arbiter, its NUM_SRC sources and
// the router injection port.
//   slave  : the arbiter side
//   master : the sources plus the router
// Flit width defaults to `HDR_SZ + `PL_SZ + `ADDR_SZ.

`ifndef HDR_SZ
`define HDR_SZ 8
`endif
`ifndef PL_SZ
`define PL_SZ 16
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

interface ni_inject_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int W       = `HDR_SZ + `PL_SZ + `ADDR_SZ
);
    logic [NUM_SRC*W-1:0] src_data;
    logic [NUM_SRC-1:0]   src_req;
    logic [NUM_SRC-1:0]   src_busy;
    logic [NUM_SRC-1:0]   src_send;
    logic [W-1:0]         out_data;
    logic                 out_req;
    logic                 out_busy;

    modport slave (
        input  src_data, src_req, out_busy,
        output src_busy, src_send, out_data, out_req
    );

    modport master (
        output src_data, src_req, out_busy,
        input  src_busy, src_send, out_data, out_req
    );
endinterface

// File: rtl/ni_inject_arbiter.sv
// Round-robin injection arbiter: NUM_SRC sources share one router injection
// port through a single registered output slot.
//
// Optional feature macro: NI_ARB_PACE_EN. When it is defined, each source gets
// a 4-bit down-counter that holds its send enable low for PACE_GAP cycles after
// each grant. When it is not defined, src_send is tied high.

`ifndef HDR_SZ
`define HDR_SZ 8
`endif
`ifndef PL_SZ
`define PL_SZ 16
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

module ni_inject_arbiter #(
    parameter int NUM_SRC  = 4,
    parameter int PACE_GAP = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    ni_inject_arbiter_if.slave     bus
);
    localparam int W  = `HDR_SZ + `PL_SZ + `ADDR_SZ;
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    if (NUM_SRC < 2 || NUM_SRC > 16) begin : g_bad_num_src
        $error("ni_inject_arbiter: NUM_SRC out of range 2..16");
    end
    if (PACE_GAP < 1 || PACE_GAP > 15) begin : g_bad_pace_gap
        $error("ni_inject_arbiter: PACE_GAP out of range 1..15");
    end

    logic [PW-1:0]      rr_ptr;
    logic [NUM_SRC-1:0] grant;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               free;

    // The slot can accept a flit when it is empty or draining this cycle.
    assign free = !bus.out_req || !bus.out_busy;

    // Circular first-requester search starting at rr_ptr; only the request
    // vector is examined, so there is no path from src_data to busy.
    always_comb begin
        int idx;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        if (free) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_SRC) idx = idx - NUM_SRC;
                if (!gnt_any && bus.src_req[idx]) begin
                    grant[idx] = 1'b1;
                    gnt_idx    = PW'(idx);
                    gnt_any    = 1'b1;
                end
            end
        end
    end

    // Losing and idle sources, and every source during reset, see busy.
    assign bus.src_busy = {NUM_SRC{reset}} | ~grant;

    // Output slot and round-robin pointer; a grant overwrites a draining flit
    // so back-to-back grants sustain one flit per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            bus.out_req  <= 1'b0;
            bus.out_data <= '0;
        end else if (gnt_any) begin
            bus.out_data <= bus.src_data[int'(gnt_idx)*W +: W];
            bus.out_req  <= 1'b1;
            rr_ptr       <= (gnt_idx == PW'(NUM_SRC - 1)) ? '0 : gnt_idx + PW'(1);
        end else if (bus.out_req && !bus.out_busy) begin
            bus.out_req  <= 1'b0;
        end
    end

`ifdef NI_ARB_PACE_EN
    logic [3:0] pace_cnt [NUM_SRC];

    // Reload on grant, otherwise count a nonzero pacing gap down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++) pace_cnt[i] <= 4'd0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant[i])
                    pace_cnt[i] <= 4'(PACE_GAP);
                else if (pace_cnt[i] != 4'd0)
                    pace_cnt[i] <= pace_cnt[i] - 4'd1;
            end
        end
    end

    // A source may inject again once its gap has expired.
    always_comb begin
        bus.src_send = '0;
        for (int i = 0; i < NUM_SRC; i++)
            bus.src_send[i] = (pace_cnt[i] == 4'd0);
    end
`else
    assign bus.src_send = '1;
`endif

endmodule

// File: tb/tb_ni_inject_arbiter.sv
// Self-checking bench for ni_inject_arbiter: directed phases followed by a
// randomized phase, all compared against a transaction-level reference model.

`ifndef HDR_SZ
`define HDR_SZ 8
`endif
`ifndef PL_SZ
`define PL_SZ 16
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 8
`endif

module tb_ni_inject_arbiter;
    localparam int N   = 4;
    localparam int W   = `HDR_SZ + `PL_SZ + `ADDR_SZ;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ni_inject_arbiter_if #(.NUM_SRC(N), .W(W)) bus ();

    ni_inject_arbiter #(.NUM_SRC(N), .PACE_GAP(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: pending flits per source, slot contents, pointer.
    bit           pend [N];
    logic [W-1:0] fl   [N];
    bit           m_req;
    logic [W-1:0] m_data;
    int           m_ptr;
    int           edge_cnt;
    int           gnt_edge [N];

    function automatic logic [W-1:0] fixed_flit(input int i);
        logic [W-1:0] f;
        f = '0;
        f[W-1:8] = {(W-8){1'b1}} & 'h5A5A5A;
        f[7:0]   = 8'(8'hA0 + i);
        return f;
    endfunction

    function automatic int model_gnt(input bit bsy);
        if (m_req && bsy) return -1;
        for (int k = 0; k < N; k++)
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_send();
        logic [N-1:0] s;
        s = '1;
`ifdef NI_ARB_PACE_EN
        for (int i = 0; i < N; i++)
            if (edge_cnt - gnt_edge[i] >= 0 && edge_cnt - gnt_edge[i] < GAP) s[i] = 1'b0;
`endif
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req  = 1'b0;
        m_data = '0;
        m_ptr  = 0;
        for (int i = 0; i < N; i++) gnt_edge[i] = -1000;
    endtask

    // One clock cycle: new flits arrive for idle sources in 'want', inputs are
    // driven, busy is checked combinationally, then registered outputs.
    task automatic step(input logic [N-1:0] want, input logic bsy, input bit fixed);
        int              g;
        logic [N-1:0]    req_v;
        logic [N*W-1:0]  data_v;
        logic [N-1:0]    exp_busy;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && want[i]) begin
                pend[i] = 1'b1;
                fl[i]   = fixed ? fixed_flit(i) : W'({$urandom, $urandom});
            end
        end
        req_v  = '0;
        data_v = '0;
        for (int i = 0; i < N; i++) begin
            req_v[i]          = pend[i];
            data_v[i*W +: W]  = fl[i];
        end
        bus.src_req  = req_v;
        bus.src_data = data_v;
        bus.out_busy = bsy;
        #1;
        g = model_gnt(bsy);
        exp_busy = '1;
        if (g >= 0) exp_busy[g] = 1'b0;
        chk("src_busy", 64'(bus.src_busy), 64'(exp_busy));
        @(posedge clk);
        edge_cnt++;
        if (g >= 0) begin
            m_data      = fl[g];
            m_req       = 1'b1;
            m_ptr       = (g + 1) % N;
            pend[g]     = 1'b0;
            gnt_edge[g] = edge_cnt;
        end else if (m_req && !bsy) begin
            m_req = 1'b0;
        end
        #1;
        chk("out_req", 64'(bus.out_req), 64'(m_req));
        chk("out_data", 64'(bus.out_data), 64'(m_data));
        chk("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
        chk("src_send", 64'(bus.src_send), 64'(model_send()));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            fl[i]   = '0;
        end
        edge_cnt     = 0;
        model_reset();
        reset        = 1'b1;
        bus.src_req  = '0;
        bus.src_data = '0;
        bus.out_busy = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.src_busy), 64'hF);
        chk("rst_out_req", 64'(bus.out_req), 64'h0);
        chk("rst_out_data", 64'(bus.out_data), 64'h0);
        chk("rst_send", 64'(bus.src_send), 64'hF);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step(4'b0000, 1'b0, 1'b0);

        // All four request continuously: order 0,1,2,3,0,...
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b0, 1'b1);
            chk("rr_order", 64'(bus.out_data), 64'(fixed_flit(k % N)));
        end
        repeat (6) step(4'b0000, 1'b0, 1'b1);

        // Back-pressure with source 2's flit in the slot
        step(4'b0100, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(4'b1011, 1'b1, 1'b1);
            chk("bp_hold", 64'(bus.out_data), 64'(fixed_flit(2)));
            chk("bp_req", 64'(bus.out_req), 64'h1);
        end
        step(4'b0000, 1'b0, 1'b1);
        chk("bp_release", 64'(bus.out_data), 64'(fixed_flit(3)));
        repeat (4) step(4'b0000, 1'b0, 1'b1);

        // Wrap and skip: pointer at 3, only sources 1 and 3 request
        step(4'b0100, 1'b0, 1'b1);
        step(4'b1010, 1'b0, 1'b1);
        chk("wrap_g3", 64'(bus.out_data), 64'(fixed_flit(3)));
        chk("wrap_ptr0", 64'(dut.rr_ptr), 64'h0);
        step(4'b1010, 1'b0, 1'b1);
        chk("wrap_g1", 64'(bus.out_data), 64'(fixed_flit(1)));
        step(4'b1010, 1'b0, 1'b1);
        chk("wrap_g3b", 64'(bus.out_data), 64'(fixed_flit(3)));
        repeat (4) step(4'b0000, 1'b0, 1'b1);

        // Pacing of source 1
        step(4'b0010, 1'b0, 1'b1);
`ifdef NI_ARB_PACE_EN
        chk("pace_t1", 64'(bus.src_send), 64'b1101);
        step(4'b0000, 1'b0, 1'b1);
        chk("pace_t2", 64'(bus.src_send), 64'b1101);
        step(4'b0000, 1'b0, 1'b1);
        chk("pace_t3", 64'(bus.src_send), 64'b1111);
`else
        chk("send_tied", 64'(bus.src_send), 64'hF);
        repeat (2) step(4'b0000, 1'b0, 1'b1);
`endif

        // Reset mid-transfer with a flit held under back-pressure
        step(4'b0001, 1'b1, 1'b1);
        step(4'b0100, 1'b1, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", 64'(bus.out_req), 64'h0);
        chk("mid_rst_data", 64'(bus.out_data), 64'h0);
        chk("mid_rst_busy", 64'(bus.src_busy), 64'hF);
        chk("mid_rst_ptr", 64'(dut.rr_ptr), 64'h0);
        chk("mid_rst_send", 64'(bus.src_send), 64'hF);
        @(posedge clk);
        edge_cnt++;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step(4'b0000, 1'b0, 1'b1);

        // Randomized traffic and back-pressure
        for (int k = 0; k < 400; k++)
            step(N'($urandom), ($urandom_range(0, 9) < 3), 1'b0);
        repeat (10) step(4'b0000, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
